// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, multi-cycle EX sequencing and flush/redirect.
// Optional stall-cycle performance counter enabled by defining PIPE_CTRL_PERF_EN.
//
// state | meaning
// RUN   | normal issue; stalls follow stallreq_ex / stallreq_id, multi-cycle ops may start
// MULTI | multi-cycle EX operation in progress, mc_cnt counts remaining cycles down to 1
// FLUSH | one-cycle flush pulse on flush_o with the redirect target on new_pc_o
module pipe_ctrl #(
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_id,
    input  logic            stallreq_ex,
    input  logic            mc_start_i,
    input  logic [MC_W-1:0] mc_cycles_i,
    input  logic            flush_req_i,
    input  logic [31:0]     new_pc_i,
    output logic [5:0]      stall_o,
    output logic            flush_o,
    output logic [31:0]     new_pc_o,
    output logic            mc_done_o,
    output logic [31:0]     stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t          state, state_nxt;
    logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;
    logic [MC_W-1:0] mc_len;
    logic            flush_nxt;
    logic [31:0]     new_pc_nxt;
    logic [5:0]      stall_raw;
    logic            done_raw;

    assign mc_len = (mc_cycles_i == '0) ? MC_W'(1) : mc_cycles_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            mc_cnt   <= '0;
            flush_o  <= 1'b0;
            new_pc_o <= 32'h0;
        end else begin
            state    <= state_nxt;
            mc_cnt   <= mc_cnt_nxt;
            flush_o  <= flush_nxt;
            new_pc_o <= new_pc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        flush_nxt  = 1'b0;
        new_pc_nxt = new_pc_o;
        stall_raw  = STALL_NONE;
        done_raw   = 1'b0;
        if (flush_req_i) begin
            // Flush wins over everything and silently aborts any multi-cycle op.
            state_nxt  = FLUSH;
            mc_cnt_nxt = '0;
            flush_nxt  = 1'b1;
            new_pc_nxt = new_pc_i;
        end else begin
            case (state)
                RUN: begin
                    if (mc_start_i) begin
                        stall_raw = STALL_EX;
                        if (mc_len == MC_W'(1)) begin
                            done_raw = 1'b1;
                        end else begin
                            mc_cnt_nxt = mc_len - MC_W'(1);
                            state_nxt  = MULTI;
                        end
                    end else if (stallreq_ex) begin
                        stall_raw = STALL_EX;
                    end else if (stallreq_id) begin
                        stall_raw = STALL_ID;
                    end
                end
                MULTI: begin
                    stall_raw = STALL_EX;
                    if (mc_cnt == MC_W'(1)) begin
                        done_raw   = 1'b1;
                        mc_cnt_nxt = '0;
                        state_nxt  = RUN;
                    end else begin
                        mc_cnt_nxt = mc_cnt - MC_W'(1);
                    end
                end
                FLUSH: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt  = RUN;
                    mc_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign stall_o   = rst ? stall_raw : STALL_NONE;
    assign mc_done_o = rst & done_raw;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= 32'h0;
        end else if ((stall_o != STALL_NONE) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle reference model comparison plus
// hand-computed literal checks for the directed scenarios.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, mc_start_i, flush_req_i;
    logic [5:0]  mc_cycles_i;
    logic [31:0] new_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o, mc_done_o;
    logic [31:0] new_pc_o, stall_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_ctrl #(.MC_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .mc_start_i  (mc_start_i),
        .mc_cycles_i (mc_cycles_i),
        .flush_req_i (flush_req_i),
        .new_pc_i    (new_pc_i),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .new_pc_o    (new_pc_o),
        .mc_done_o   (mc_done_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: cycles of multi-cycle stall still owed after this one,
    // whether a flush pulse is being shown, redirect target and stall count.
    int          m_left  = 0;
    bit          m_flush = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    longint      m_cnt   = 0;

    function automatic int eff_len();
        return (mc_cycles_i == 0) ? 1 : int'(mc_cycles_i);
    endfunction

    function automatic logic [5:0] exp_stall();
        if (!rst || flush_req_i || m_flush) return 6'b000000;
        if (m_left > 0 || mc_start_i || stallreq_ex) return 6'b001111;
        if (stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic exp_done();
        if (!rst || flush_req_i || m_flush) return 1'b0;
        if (m_left > 0) return (m_left == 1);
        if (mc_start_i) return (eff_len() == 1);
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_left  <= 0;
            m_flush <= 1'b0;
            m_pc    <= 32'h0;
            m_cnt   <= 0;
        end else begin
`ifdef PIPE_CTRL_PERF_EN
            if (exp_stall() != 6'b0 && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt <= m_cnt + 1;
`endif
            if (flush_req_i) begin
                m_flush <= 1'b1;
                m_pc    <= new_pc_i;
                m_left  <= 0;
            end else begin
                m_flush <= 1'b0;
                if (m_flush) m_left <= 0;
                else if (m_left > 0) m_left <= m_left - 1;
                else if (mc_start_i) m_left <= eff_len() - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    bit model_on = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("model stall_o",     32'(stall_o),   32'(exp_stall()));
            chk("model mc_done_o",   32'(mc_done_o), 32'(exp_done()));
            chk("model flush_o",     32'(flush_o),   32'(m_flush));
            chk("model new_pc_o",    new_pc_o,       m_pc);
            chk("model stall_cnt_o", stall_cnt_o,    m_cnt[31:0]);
        end
    end

    task automatic drive(input logic r, input logic id, input logic ex, input logic st,
                         input logic [5:0] n, input logic fl, input logic [31:0] pc);
        rst = r; stallreq_id = id; stallreq_ex = ex; mc_start_i = st;
        mc_cycles_i = n; flush_req_i = fl; new_pc_i = pc;
        #2;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 6'd0, 0, 32'h0);
    endtask

    logic [31:0] cnt0;
    int          ex_delta;

    initial begin
`ifdef PIPE_CTRL_PERF_EN
        ex_delta = 5;
`else
        ex_delta = 0;
`endif
        // Reset held with a flush request: reset must win.
        drive(0, 1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
        chk("reset stall_o comb", 32'(stall_o), 32'h0);
        chk("reset mc_done comb", 32'(mc_done_o), 32'h0);
        adv();
        model_on = 1'b1;
        drive(0, 0, 0, 0, 6'd0, 1, 32'h1234_5678);
        adv();
        idle();
        chk("reset flush_o", 32'(flush_o), 32'h0);
        chk("reset new_pc_o", new_pc_o, 32'h0);
        chk("reset stall_cnt_o", stall_cnt_o, 32'h0);
        chk("idle stall_o", 32'(stall_o), 32'h0);
        adv();

        // Scenario 1: ID stall for two cycles.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 6'd0, 0, 32'h0);
            chk("s1 id stall", 32'(stall_o), 32'h07);
            adv();
        end
        idle();
        chk("s1 released", 32'(stall_o), 32'h0);
        adv();

        // Scenario 2: EX stall outranks ID stall.
        drive(1, 1, 1, 0, 6'd0, 0, 32'h0);
        chk("s2 ex over id", 32'(stall_o), 32'h0F);
        adv();

        // Scenario 3: 5-cycle op; a second start inside MULTI is ignored.
        cnt0 = stall_cnt_o;
        for (int i = 1; i <= 5; i++) begin
            if (i == 1)      drive(1, 0, 0, 1, 6'd5, 0, 32'h0);
            else if (i == 3) drive(1, 0, 0, 1, 6'd2, 0, 32'h0);
            else             idle();
            chk("s3 multi stall", 32'(stall_o), 32'h0F);
            chk("s3 done timing", 32'(mc_done_o), (i == 5) ? 32'h1 : 32'h0);
            adv();
        end
        idle();
        chk("s3 stall ends", 32'(stall_o), 32'h0);
        chk("s3 stall_cnt delta", stall_cnt_o - cnt0, 32'(ex_delta));
        adv();

        // Scenario 4: length 0 and 1 both give a single-cycle op.
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 1, 6'(k), 0, 32'h0);
            chk("s4 single stall", 32'(stall_o), 32'h0F);
            chk("s4 single done", 32'(mc_done_o), 32'h1);
            adv();
            idle();
            chk("s4 back in run", 32'(stall_o), 32'h0);
            adv();
        end

        // Scenario 5: flush in cycle 3 of a 5-cycle op.
        drive(1, 0, 0, 1, 6'd5, 0, 32'h0);
        adv();
        idle();
        adv();
        drive(1, 0, 1, 0, 6'd0, 1, 32'h0000_0020);
        chk("s5 req cycle stall", 32'(stall_o), 32'h0);
        chk("s5 req cycle done", 32'(mc_done_o), 32'h0);
        adv();
        drive(1, 1, 0, 1, 6'd3, 0, 32'h0);
        chk("s5 flush_o", 32'(flush_o), 32'h1);
        chk("s5 new_pc_o", new_pc_o, 32'h0000_0020);
        chk("s5 flush stall", 32'(stall_o), 32'h0);
        chk("s5 flush done", 32'(mc_done_o), 32'h0);
        adv();
        idle();
        chk("s5 flush drops", 32'(flush_o), 32'h0);
        chk("s5 pc holds", new_pc_o, 32'h0000_0020);
        chk("s5 run again", 32'(stall_o), 32'h0);
        adv();

        // Back-to-back flushes: FLUSH repeats with the newer target.
        drive(1, 0, 0, 0, 6'd0, 1, 32'h0000_0100);
        adv();
        drive(1, 0, 0, 0, 6'd0, 1, 32'h0000_0200);
        adv();
        idle();
        chk("refl flush_o", 32'(flush_o), 32'h1);
        chk("refl new_pc_o", new_pc_o, 32'h0000_0200);
        adv();
        idle();
        adv();

        // Scenario 6: reset during MULTI, then a clean restart.
        drive(1, 0, 0, 1, 6'd5, 0, 32'h0);
        adv();
        drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
        chk("s6 rst comb stall", 32'(stall_o), 32'h0);
        chk("s6 rst comb done", 32'(mc_done_o), 32'h0);
        adv();
        idle();
        chk("s6 after rst stall", 32'(stall_o), 32'h0);
        chk("s6 after rst done", 32'(mc_done_o), 32'h0);
        chk("s6 after rst pc", new_pc_o, 32'h0);
        chk("s6 after rst cnt", stall_cnt_o, 32'h0);
        adv();
        for (int i = 1; i <= 3; i++) begin
            if (i == 1) drive(1, 0, 0, 1, 6'd3, 0, 32'h0);
            else        idle();
            chk("s6 restart stall", 32'(stall_o), 32'h0F);
            chk("s6 restart done", 32'(mc_done_o), (i == 3) ? 32'h1 : 32'h0);
            adv();
        end

        // Mixed sequence left to the model.
        for (int i = 0; i < 40; i++) begin
            drive(1, 1'(i % 3 == 0), 1'(i % 5 == 1), 1'(i % 7 == 2), 6'(i % 4),
                  1'(i % 11 == 6), 32'(i * 4));
            adv();
        end
        idle();
        adv();
        model_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
